// File: rtl/button_counter.sv
// Debounced, saturating up/down counter driven by two active-low push buttons.
// Optional auto-repeat on held buttons: define BUTTON_COUNTER_HOLD_REPEAT_EN.
module button_counter #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up_n,
  input  logic             btn_down_n,
  input  logic             clear,
  output logic [WIDTH-1:0] count_out,
  output logic             changed
);

  localparam int unsigned     CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  if (DEBOUNCE_CYCLES == 0 || REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("button_counter: invalid parameter combination");
  end

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]       r_sync1, r_sync2;
  logic [1:0]       r_pressed, w_pressed_nxt;
  logic [1:0]       r_evt, w_evt_nxt;
  logic [CW-1:0]    r_db_cnt [2];
  logic [CW-1:0]    w_db_cnt_nxt [2];
  logic [1:0]       w_rep;
  logic [1:0]       w_step;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic             r_changed, w_changed_nxt;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_pressed_nxt[i] = r_pressed[i];
      w_evt_nxt[i]     = 1'b0;
      w_db_cnt_nxt[i]  = '0;
      if (~r_sync2[i] != r_pressed[i]) begin
        if (r_db_cnt[i] == DB_LAST) begin
          w_pressed_nxt[i] = ~r_pressed[i];
          w_evt_nxt[i]     = ~r_pressed[i];
        end else begin
          w_db_cnt_nxt[i] = r_db_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 2'b11;
      r_sync2   <= 2'b11;
      r_pressed <= 2'b00;
      r_evt     <= 2'b00;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= {btn_down_n, btn_up_n};
      r_sync2   <= r_sync1;
      r_pressed <= w_pressed_nxt;
      r_evt     <= w_evt_nxt;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= w_db_cnt_nxt[i];
    end
  end

`ifdef BUTTON_COUNTER_HOLD_REPEAT_EN
  // Hold counter restarts at 1 on the press event and again after each repeat.
  logic [1:0]  r_hold_act, r_hold_rep;
  logic [31:0] r_hold_cnt [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_rep[i] = r_hold_act[i] &&
                 (r_hold_cnt[i] == (r_hold_rep[i] ? REPEAT_PERIOD : REPEAT_DELAY));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_act <= 2'b00;
      r_hold_rep <= 2'b00;
      for (int i = 0; i < 2; i++) r_hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clear || !r_pressed[i]) begin
          r_hold_act[i] <= 1'b0;
          r_hold_rep[i] <= 1'b0;
          r_hold_cnt[i] <= '0;
        end else if (r_evt[i]) begin
          r_hold_act[i] <= 1'b1;
          r_hold_rep[i] <= 1'b0;
          r_hold_cnt[i] <= 32'd1;
        end else if (w_rep[i]) begin
          r_hold_rep[i] <= 1'b1;
          r_hold_cnt[i] <= 32'd1;
        end else if (r_hold_act[i]) begin
          r_hold_cnt[i] <= r_hold_cnt[i] + 32'd1;
        end
      end
    end
  end
`else
  assign w_rep = 2'b00;
`endif

  assign w_step = r_evt | w_rep;

  always_comb begin
    w_count_nxt   = r_count;
    w_changed_nxt = 1'b0;
    if (clear) begin
      if (r_count != '0) begin
        w_count_nxt   = '0;
        w_changed_nxt = 1'b1;
      end
    end else if (w_step[0] && w_step[1]) begin
      w_count_nxt = r_count;
    end else if (w_step[0]) begin
      if (r_count != CNT_MAX) begin
        w_count_nxt   = r_count + WIDTH'(1);
        w_changed_nxt = 1'b1;
      end
    end else if (w_step[1]) begin
      if (r_count != '0) begin
        w_count_nxt   = r_count - WIDTH'(1);
        w_changed_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_changed <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_changed <= w_changed_nxt;
    end
  end

  assign count_out = r_count;
  assign changed   = r_changed;

endmodule

// File: tb/tb_button_counter.sv
// Directed bench for button_counter (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5).
module tb_button_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up_n = 1'b1;
  logic        btn_down_n = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] count_out;
  logic        changed;

  // Narrow instance so saturation at the top is reachable in a short run.
  logic        s_up_n = 1'b1;
  logic        s_down_n = 1'b1;
  logic [1:0]  s_count;
  logic        s_changed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_counter #(
    .WIDTH(16), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
    .clear(clear), .count_out(count_out), .changed(changed)
  );

  button_counter #(
    .WIDTH(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .btn_up_n(s_up_n), .btn_down_n(s_down_n),
    .clear(1'b0), .count_out(s_count), .changed(s_changed)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the selected buttons low, then release; returns number of changed pulses seen.
  task automatic press(input logic up, input logic dn, input int hold, input int gap,
                       output int pulses);
    pulses = 0;
    btn_up_n   = ~up;
    btn_down_n = ~dn;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      if (changed) pulses++;
    end
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;
    for (int i = 0; i < gap; i++) begin
      tick(1);
      if (changed) pulses++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    n_tests++;
    if (count_out !== 16'd0) begin
      n_fail++; $display("FAIL reset_count got %0d want 0", count_out);
    end
    n_tests++;
    if (changed !== 1'b0) begin
      n_fail++; $display("FAIL reset_changed got %b want 0", changed);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_down_at_zero;
    int p;
    press(1'b0, 1'b1, 10, 10, p);
    n_tests++;
    if (count_out !== 16'd0 || p !== 0) begin
      n_fail++; $display("FAIL down_at_zero got count=%0d pulses=%0d want 0/0", count_out, p);
    end
  endtask

  task automatic test_clean_press;
    int p;
    btn_up_n = 1'b0;
    tick(6);
    n_tests++;
    if (count_out !== 16'd0) begin
      n_fail++; $display("FAIL press_early got %0d want 0", count_out);
    end
    tick(1);
    n_tests++;
    if (count_out !== 16'd1 || changed !== 1'b1) begin
      n_fail++; $display("FAIL press_latency got count=%0d changed=%b want 1/1", count_out, changed);
    end
    tick(1);
    n_tests++;
    if (changed !== 1'b0) begin
      n_fail++; $display("FAIL press_pulse_width got changed=%b want 0", changed);
    end
    tick(2);
    press(1'b0, 1'b0, 0, 12, p);
    n_tests++;
    if (count_out !== 16'd1 || p !== 0) begin
      n_fail++; $display("FAIL release_no_event got count=%0d pulses=%0d want 1/0", count_out, p);
    end
  endtask

  task automatic test_bounce;
    int p = 0;
    for (int k = 0; k < 4; k++) begin
      btn_up_n = (k % 2 == 1);
      for (int i = 0; i < 2; i++) begin
        tick(1);
        if (changed) p++;
      end
    end
    btn_up_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (changed) p++;
    end
    n_tests++;
    if (count_out !== 16'd1) begin
      n_fail++; $display("FAIL bounce_early got %0d want 1", count_out);
    end
    tick(1);
    if (changed) p++;
    n_tests++;
    if (count_out !== 16'd2) begin
      n_fail++; $display("FAIL bounce_latency got %0d want 2", count_out);
    end
    btn_up_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (changed) p++;
    end
    n_tests++;
    if (count_out !== 16'd2 || p !== 1) begin
      n_fail++; $display("FAIL bounce_single got count=%0d pulses=%0d want 2/1", count_out, p);
    end
  endtask

  task automatic test_simultaneous;
    int p;
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10, 10, p);
    n_tests++;
    if (count_out !== 16'd5) begin
      n_fail++; $display("FAIL sim_setup got %0d want 5", count_out);
    end
    press(1'b1, 1'b1, 12, 10, p);
    n_tests++;
    if (count_out !== 16'd5 || p !== 0) begin
      n_fail++; $display("FAIL simultaneous got count=%0d pulses=%0d want 5/0", count_out, p);
    end
  endtask

  task automatic test_clear;
    int p;
    for (int i = 0; i < 2; i++) press(1'b1, 1'b0, 10, 10, p);
    n_tests++;
    if (count_out !== 16'd7) begin
      n_fail++; $display("FAIL clear_setup got %0d want 7", count_out);
    end
    clear = 1'b1;
    tick(1);
    n_tests++;
    if (count_out !== 16'd0 || changed !== 1'b1) begin
      n_fail++; $display("FAIL clear_apply got count=%0d changed=%b want 0/1", count_out, changed);
    end
    tick(1);
    n_tests++;
    if (changed !== 1'b0) begin
      n_fail++; $display("FAIL clear_pulse_width got changed=%b want 0", changed);
    end
    // Button pressed and debounced while clear is held must never count.
    p = 0;
    btn_up_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (changed) p++;
    end
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (changed) p++;
    end
    btn_up_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (changed) p++;
    end
    n_tests++;
    if (count_out !== 16'd0 || p !== 0) begin
      n_fail++; $display("FAIL clear_held_button got count=%0d pulses=%0d want 0/0", count_out, p);
    end
    clear = 1'b1;
    tick(1);
    n_tests++;
    if (count_out !== 16'd0 || changed !== 1'b0) begin
      n_fail++; $display("FAIL clear_at_zero got count=%0d changed=%b want 0/0", count_out, changed);
    end
    clear = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid;
    int p;
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10, 10, p);
    n_tests++;
    if (count_out !== 16'd3) begin
      n_fail++; $display("FAIL rstmid_setup got %0d want 3", count_out);
    end
    btn_up_n = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (count_out !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_async got %0d want 0", count_out);
    end
    tick(2);
    rst_n = 1'b1;
    tick(6);
    n_tests++;
    if (count_out !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_early got %0d want 0", count_out);
    end
    tick(1);
    n_tests++;
    if (count_out !== 16'd1) begin
      n_fail++; $display("FAIL rstmid_held_press got %0d want 1", count_out);
    end
    btn_up_n = 1'b1;
    tick(12);
  endtask

  task automatic test_hold;
    logic [15:0] want;
`ifdef BUTTON_COUNTER_HOLD_REPEAT_EN
    want = 16'd6;
`else
    want = 16'd2;
`endif
    btn_up_n = 1'b0;
    tick(45);
    n_tests++;
    if (count_out !== want) begin
      n_fail++; $display("FAIL hold got %0d want %0d", count_out, want);
    end
    btn_up_n = 1'b1;
    tick(20);
  endtask

  task automatic test_saturation;
    int p = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        n_tests++;
        if (s_count !== 2'd3 || p !== 3) begin
          n_fail++; $display("FAIL sat_setup got count=%0d pulses=%0d want 3/3", s_count, p);
        end
        p = 0;
      end
      s_up_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (s_changed) p++;
      end
      s_up_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (s_changed) p++;
      end
    end
    n_tests++;
    if (s_count !== 2'd3 || p !== 0) begin
      n_fail++; $display("FAIL sat_max got count=%0d pulses=%0d want 3/0", s_count, p);
    end
  endtask

  initial begin
    test_reset();
    test_down_at_zero();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_clear();
    test_reset_mid();
    test_hold();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/button_counter.md
Name: button_counter

Overview:
- Upstream stage of the LED display core: turns two raw push-button inputs (up/down) into a debounced, saturating up/down count.
- count_out drives the display core's num_in directly.
- Sits between the board keys (active-low, bouncy, asynchronous) and the LED display logic.
- Provides a one-cycle change strobe for any other consumer.

Parameters:
- WIDTH, 16, width of count_out; matches the display core's input width.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); minimum 1.
- REPEAT_DELAY, 25000000, hold time in cycles before auto-repeat starts. Used only with HOLD_REPEAT_EN.
- REPEAT_PERIOD, 5000000, cycles between auto-repeat steps. Used only with HOLD_REPEAT_EN.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_up_n  input  1  raw up key, active-low, asynchronous to clk
- btn_down_n  input  1  raw down key, active-low, asynchronous to clk
- clear  input  1  synchronous clear of the count, active-high
- count_out  output  WIDTH  current count, unsigned
- changed  output  1  one-cycle pulse in the cycle count_out takes a new value

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: count_out=0, changed=0, both debounced states=released, synchronizers=1 (released), debounce counters=0.
- Synchronizer: each raw input passes through a 2-flop synchronizer before any other use.
- Debouncer (per button, independent), two states, STABLE_RELEASED and STABLE_PRESSED:
  - A counter increments each cycle the synchronized level differs from the stable state.
  - The counter returns to 0 on any cycle the levels agree.
  - When the counter reaches DEBOUNCE_CYCLES, the stable state toggles and the counter returns to 0.
- Press event: a single-cycle pulse on the STABLE_RELEASED -> STABLE_PRESSED transition only. Releases produce no event.
- Latency: after a raw edge with no further bounce, the stable state changes 2+DEBOUNCE_CYCLES cycles later. count_out and changed update on the following clock edge.
- Count update priority, evaluated each cycle:
  1. clear: if count_out != 0, set count_out=0 and changed=1. If count_out is already 0, changed=0.
  2. Up and down events in the same cycle: no change, changed=0.
  3. Up event: count_out+1, saturating at 2^WIDTH-1. At the maximum, no change and changed=0.
  4. Down event: count_out-1, saturating at 0. At 0, no change and changed=0.
- No wrap-around in either direction.
- changed is high for exactly one cycle per actual value change and is never asserted when the value is unchanged.
- clear held high suppresses all button events while asserted. The debouncers keep tracking during clear, so a button held through clear generates no late event.
- Reset mid-operation: all state returns to reset values immediately.
  - A button still physically held when reset deasserts starts as released in the debouncer. It then produces one press event after 2+DEBOUNCE_CYCLES cycles.

Optional Feature:
- Macro: BUTTON_COUNTER_HOLD_REPEAT_EN.
- Defined:
  - Each debounced button has a hold counter that starts at its press event.
  - After REPEAT_DELAY cycles still pressed, the button emits a repeat event, then another every REPEAT_PERIOD cycles while it stays pressed.
  - Repeat events follow the same priority and saturation rules as press events.
  - Release or clear resets the hold counter.
  - Both buttons held: the events cancel per the simultaneous rule.
- Undefined:
  - No hold counters are synthesized and REPEAT_* parameters are ignored.
  - Exactly one step per press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5 for simulation):
- Reset, then one clean press of btn_up_n held 10 cycles -> count_out 0->1 exactly 2+4+1 cycles after the falling edge; changed pulses once; release causes no change.
- Up press with bounce (toggle every 2 cycles for 8 cycles, then held low) -> exactly one increment, counted from the final stable edge.
- count_out=65535, up press -> stays 65535, changed=0. count_out=0, down press -> stays 0, changed=0.
- Up and down pressed on the same cycle from count 5 -> count_out stays 5, changed=0. clear asserted with count 7 -> count_out=0 next cycle, changed=1 for one cycle.
- rst_n asserted low mid-debounce with count 3 -> count_out=0 asynchronously. Button still held at release of reset -> one increment 6 cycles later.
- With BUTTON_COUNTER_HOLD_REPEAT_EN, hold up for 40 cycles after the press event -> increments at event, +20, +25, +30, +35 (count 0->5). Without the macro -> count 0->1.
